// File: rtl/key_history_if.sv
// Keypad history bus: debouncer-side controls in, history/read-port state out.
// Pure wiring, no storage; the slave modport is the history buffer itself.
// No flow control: strobes are edge events, outputs are always valid.
interface key_history_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Controls toward the history buffer
    logic                   pulse;
    logic [WIDTH-1:0]       key;
    logic                   undo;
    logic                   clear;
    logic                   suppress_repeat;
    logic [IW-1:0]          sel;

    // State reported by the history buffer
    logic [DEPTH*WIDTH-1:0] history;
    logic [DEPTH-1:0]       valid;
    logic [CW-1:0]          count;
    logic                   full;
    logic [WIDTH-1:0]       sel_data;
    logic                   pushed;

    modport master (
        output pulse, key, undo, clear, suppress_repeat, sel,
        input  history, valid, count, full, sel_data, pushed
    );

    modport slave (
        input  pulse, key, undo, clear, suppress_repeat, sel,
        output history, valid, count, full, sel_data, pushed
    );
endinterface

// File: rtl/key_history.sv
// Newest-first keypad entry history with undo, clear, repeat suppression and indexed read.
// Latency: one clk from the pulse/undo rising edge to updated history; sel_data is combinational.
// No backpressure: every detected edge is acted on; a push into a full history drops the oldest entry.
module key_history #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    key_history_if.slave  kh
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Edge detector state
    logic pulse_q;
    logic undo_q;
    logic push_ev;
    logic pop_ev;

    // History storage: entry 0 is the newest key
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             pushed_q;
    logic             pushed_d;

    // Decoded helpers, all from registered state
    logic has_entries;
    logic is_full;
    logic suppress_hit;

    assign push_ev      = kh.pulse & ~pulse_q;
    assign pop_ev       = kh.undo  & ~undo_q;
    assign has_entries  = valid_q[0];
    assign is_full      = (count_q == CW'(DEPTH));
    // Repeat suppression looks at the entry 0 held before this edge
    assign suppress_hit = kh.suppress_repeat & valid_q[0] & (kh.key == entry_q[0]);

    // Remember last sampled strobe levels; keeps running through clear so a
    // pulse held across clear release is not mistaken for a new key
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q <= 1'b0;
            undo_q  <= 1'b0;
        end else begin
            pulse_q <= kh.pulse;
            undo_q  <= kh.undo;
        end
    end

    // Next-state selection in priority order: clear, replace, suppress, push, pop, hold
    always_comb begin
        entry_d  = entry_q;
        valid_d  = valid_q;
        count_d  = count_q;
        pushed_d = 1'b0;

        if (kh.clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i] = '0;
            end
            valid_d = '0;
            count_d = '0;
        end else if (push_ev && pop_ev && has_entries) begin
            // Simultaneous key and backspace overwrite the newest entry in place
            entry_d[0] = kh.key;
            pushed_d   = 1'b1;
        end else if (push_ev && suppress_hit) begin
            // Same key as the newest entry while suppression is on: ignore it
            pushed_d = 1'b0;
        end else if (push_ev) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                entry_d[i] = entry_q[i-1];
            end
            entry_d[0] = kh.key;
            valid_d    = {valid_q[DEPTH-2:0], 1'b1};
            if (!is_full) begin
                count_d = count_q + CW'(1);
            end
            pushed_d   = 1'b1;
        end else if (pop_ev && has_entries) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entry_d[i] = entry_q[i+1];
            end
            entry_d[DEPTH-1] = '0;
            valid_d          = {1'b0, valid_q[DEPTH-1:1]};
            count_d          = count_q - CW'(1);
        end
    end

    // History, occupancy and pushed-flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q  <= '0;
            count_q  <= '0;
            pushed_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            valid_q  <= valid_d;
            count_q  <= count_d;
            pushed_q <= pushed_d;
        end
    end

    // Flatten the entries onto the history bus, entry i at [i*WIDTH +: WIDTH]
    always_comb begin
        kh.history = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kh.history[i*WIDTH +: WIDTH] = entry_q[i];
        end
    end

    // Indexed read: out-of-range or empty slots read as zero
    always_comb begin
        kh.sel_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((kh.sel == IW'(i)) && valid_q[i]) begin
                kh.sel_data = entry_q[i];
            end
        end
    end

    assign kh.valid  = valid_q;
    assign kh.count  = count_q;
    assign kh.full   = is_full;
    assign kh.pushed = pushed_q;

endmodule

// File: tb/tb_key_history.sv
// Self-checking bench for key_history: a key-queue reference model feeds a scoreboard.
// Each clocked step pushes the expected post-edge state, then pops and compares it after the edge.
// Inputs are driven 1 time unit after posedge; outputs are sampled there too.
module tb_key_history;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int IW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    key_history_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) kif ();

    key_history #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .kh    (kif.slave)
    );

    typedef struct packed {
        logic [DEPTH*WIDTH-1:0] hist;
        logic [DEPTH-1:0]       vld;
        logic [CW-1:0]          cnt;
        logic                   full;
        logic                   pushed;
    } snap_t;

    snap_t sb_q[$];

    // Reference model: keys newest-first in a queue
    int mq[$];
    bit m_pulse_q;
    bit m_undo_q;
    bit m_pushed;

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s/%s: got %0h, expected %0h (t=%0t)", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s = '0;
        for (int i = 0; i < mq.size(); i++) begin
            s.hist[i*WIDTH +: WIDTH] = WIDTH'(mq[i]);
        end
        s.vld    = DEPTH'((1 << mq.size()) - 1);
        s.cnt    = CW'(mq.size());
        s.full   = (mq.size() == DEPTH);
        s.pushed = m_pushed;
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] model_sel();
        int idx;
        idx = int'(kif.sel);
        if (idx < mq.size()) return WIDTH'(mq[idx]);
        return '0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pulse_q = 1'b0;
        m_undo_q  = 1'b0;
        m_pushed  = 1'b0;
    endtask

    // Apply the current input levels to the model as one clock edge
    task automatic model_edge();
        bit push_ev;
        bit pop_ev;
        push_ev  = kif.pulse && !m_pulse_q;
        pop_ev   = kif.undo  && !m_undo_q;
        m_pushed = 1'b0;
        if (kif.clear) begin
            mq.delete();
        end else if (push_ev && pop_ev && mq.size() > 0) begin
            mq[0]    = int'(kif.key);
            m_pushed = 1'b1;
        end else if (push_ev && kif.suppress_repeat && mq.size() > 0 && mq[0] == int'(kif.key)) begin
            m_pushed = 1'b0;
        end else if (push_ev) begin
            mq.push_front(int'(kif.key));
            if (mq.size() > DEPTH) void'(mq.pop_back());
            m_pushed = 1'b1;
        end else if (pop_ev && mq.size() > 0) begin
            void'(mq.pop_front());
        end
        m_pulse_q = kif.pulse;
        m_undo_q  = kif.undo;
    endtask

    task automatic compare_pop();
        snap_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check("history",  32'(kif.history),  32'(e.hist));
        check("valid",    32'(kif.valid),    32'(e.vld));
        check("count",    32'(kif.count),    32'(e.cnt));
        check("full",     32'(kif.full),     32'(e.full));
        check("pushed",   32'(kif.pushed),   32'(e.pushed));
        check("sel_data", 32'(kif.sel_data), 32'(model_sel()));
    endtask

    // One clock with the inputs as currently driven
    task automatic cycle();
        kif.sel = IW'($urandom_range(0, DEPTH - 1));
        model_edge();
        sb_q.push_back(model_snap());
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic press(input int k);
        kif.key   = WIDTH'(k);
        kif.pulse = 1'b1;
        cycle();
        kif.pulse = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic back();
        kif.undo = 1'b1;
        cycle();
        kif.undo = 1'b0;
        cycle();
    endtask

    task automatic check_sel_now(input int s);
        kif.sel = IW'(s);
        #1;
        check("sel_comb", 32'(kif.sel_data), 32'(model_sel()));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset               = 1'b1;
        kif.pulse           = 1'b0;
        kif.key             = '0;
        kif.undo            = 1'b0;
        kif.clear           = 1'b0;
        kif.suppress_repeat = 1'b0;
        kif.sel             = '0;
        model_reset();

        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(model_snap());
        compare_pop();
        reset = 1'b0;

        phase = "push123";
        for (int k = 1; k <= 3; k++) press(k);

        phase = "push45";
        press(4);
        press(5);

        phase = "undo1";
        back();

        phase = "hold7";
        kif.key   = 4'd7;
        kif.pulse = 1'b1;
        repeat (10) cycle();
        kif.pulse = 1'b0;
        cycle();

        phase = "suppress";
        kif.suppress_repeat = 1'b1;
        press(7);
        phase = "nosuppress";
        kif.suppress_repeat = 1'b0;
        press(7);

        phase = "undo_all";
        for (int k = 0; k < 5; k++) back();

        phase = "replace";
        press(1);
        press(2);
        kif.key   = 4'd9;
        kif.pulse = 1'b1;
        kif.undo  = 1'b1;
        cycle();
        kif.pulse = 1'b0;
        kif.undo  = 1'b0;
        cycle();

        phase = "clear";
        kif.key   = 4'd3;
        kif.pulse = 1'b1;
        kif.clear = 1'b1;
        repeat (2) cycle();
        kif.clear = 1'b0;
        cycle();
        kif.pulse = 1'b0;
        cycle();

        phase = "replace_empty";
        kif.key   = 4'd5;
        kif.pulse = 1'b1;
        kif.undo  = 1'b1;
        cycle();
        kif.pulse = 1'b0;
        kif.undo  = 1'b0;
        cycle();

        phase = "sel";
        kif.clear = 1'b1;
        cycle();
        kif.clear = 1'b0;
        press(8);
        check_sel_now(1);
        check_sel_now(0);

        phase = "async_reset";
        press(2);
        press(4);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        sb_q.push_back(model_snap());
        compare_pop();
        kif.key   = 4'd6;
        kif.pulse = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        phase = "reset_release";
        cycle();
        kif.pulse = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_history.md
# key_history

Parametrised keypad entry history buffer for the keypad/seven-segment display path. It sits between the keypad debouncer and the display multiplexer. It captures a debounced key code on each new-key strobe into a DEPTH-entry, newest-first shift history. It adds edge detection, backspace (undo), clear, repeat suppression and an indexed read port.

## Interface
- WIDTH, 4, bits per key code
- DEPTH, 4, number of history entries (≥2); entry 0 is newest ("current"), entry 1 is "last"
- IW, $clog2(DEPTH), derived, index width
- CW, $clog2(DEPTH+1), derived, count width
- clk  in  1  system clock (~12 MHz)
- reset  in  1  asynchronous, active-high reset
- pulse  in  1  new-key strobe from debouncer; rising edge (sampled on clk) is one push event
- key  in  WIDTH  debounced key code, sampled on the push edge
- undo  in  1  backspace request; rising edge is one pop event
- clear  in  1  level; synchronous clear of whole history
- suppress_repeat  in  1  mode; 1 = ignore push whose key equals valid entry 0
- sel  in  IW  read index
- history  out  DEPTH*WIDTH  entry i at bits [i*WIDTH +: WIDTH]
- valid  out  DEPTH  valid[i] = entry i holds a key
- count  out  CW  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH
- sel_data  out  WIDTH  entry sel; 0 if sel ≥ DEPTH or !valid[sel] (combinational from registers)
- pushed  out  1  one-cycle flag: a push or replace was accepted on the previous edge

## Operation
- Edge detect: pulse_q, undo_q registered copies. push_ev = pulse & ~pulse_q. pop_ev = undo & ~undo_q. A held pulse or undo produces exactly one event.
- Invariants: valid is always a contiguous mask from bit 0 (valid = 2^count − 1). Invalid entries always hold 0.
- Per-edge priority, highest first:
  - clear = 1: all entries 0, valid 0, count 0, pushed 0. Edge detectors still update, so a pulse held across clear release does not push.
  - push_ev & pop_ev together, count > 0: replace. entry0 <= key; count unchanged; pushed = 1. With count = 0, treated as a plain push.
  - push_ev, suppressed: suppress_repeat = 1, valid[0] = 1 and key == entry0. No change; pushed = 0.
  - push_ev, accepted: entry[i] <= entry[i−1] for i ≥ 1; entry0 <= key; valid shifts in 1; count <= min(count+1, DEPTH); pushed = 1. When full, the oldest entry is discarded and count stays DEPTH.
  - pop_ev: entry[i] <= entry[i+1]; entry[DEPTH−1] <= 0; valid shifts down; count−1. With count = 0 this is a no-op.
  - Otherwise: hold; pushed = 0.
- The replace and suppress checks use entry0 before the edge. Suppression never applies to replace.
- full and count are registered (or decoded from registered valid), never from next-state.

## Timing
- Reset (async assert, release synchronous to design): history 0, valid 0, count 0, full 0, pushed 0, pulse_q 0, undo_q 0. sel_data is therefore 0.
- Latency: pulse rises before edge k, so history/valid/count reflect the push after edge k. pushed is high from edge k to edge k+1.
- pulse or undo must be low for ≥1 sampled cycle between events. A high-low-high within one clock period is not guaranteed to produce two events.
- key must be stable on the edge where push_ev is true. No other setup requirement.
- Reset mid-operation clears everything immediately, regardless of clk. The first edge after release with pulse already high counts as a push (pulse_q = 0).
- sel_data follows sel combinationally in the same cycle. It follows history one cycle after the push edge.

## Test plan
- Reset, then push 1,2,3 (one-cycle pulses 200 µs apart): history = {entry0 3, entry1 2, entry2 1, entry3 0}, valid 0111, count 3, full 0, pushed high exactly 3 single cycles.
- From above, push 4 then 5: entries 5,4,3,2, valid 1111, count 4, full 1; key 1 is discarded.
- Hold pulse high 10 cycles with key 7, then release: exactly one push, count+1, one pushed cycle. With suppress_repeat = 1, a second push of 7 → no change, pushed stays 0. With suppress_repeat = 0 → 7 pushed again.
- Entries 5,4,3,2: undo edge → 4,3,2,0, count 3. Four more undos → all 0, count 0; final undo is a no-op. Simultaneous pulse/undo edges with key 9 at count 2 → entry0 = 9, count 2, pushed 1.
- clear asserted while pulse held: history 0, count 0; no push on clear release. sel = 1 with count 1 → sel_data 0; sel = 0 → entry0.
- Assert reset asynchronously between clock edges with count 3: all outputs 0 before the next clk edge. Release with pulse high and key 6 → first edge pushes 6, count 1.
